clken_gen: RTL and testbench
============================

CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 SHALL have parameter NCH, default 2: number of clock-enable channels, legal range 1..8.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator, numerator, denominator and phase width.
REQ-003 SHALL have parameter LOCK_CYCLES, default 64: settle count before locked asserts, legal range 1..65535.
REQ-004 SHALL have port refclk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-007 SHALL have port cfg_ready, output, 1 bit: the block can accept a write.
REQ-008 SHALL have port cfg_ch, input, 3 bits: target channel index.
REQ-009 SHALL have port cfg_num, input, ACC_W bits: numerator, the number of enables per den cycles.
REQ-010 SHALL have port cfg_den, input, ACC_W bits: denominator.
REQ-011 SHALL have port cfg_phase, input, ACC_W bits: initial accumulator value, which sets the phase offset.
REQ-012 SHALL have port resync, input, 1 bit: reload all accumulators with their stored phases.
REQ-013 SHALL have port cen, output, NCH bits: registered one-cycle clock-enable pulses, one bit per channel.
REQ-014 SHALL have port locked, output, 1 bit: all channels are settled on their current configuration.

Function
REQ-015 SHALL store num, den, phase and acc registers for each channel.
REQ-016 SHALL accept a write on any edge where cfg_valid=1 and cfg_ready=1.
REQ-017 SHALL drive cfg_ready=0 for exactly the one cycle after each accept, so the maximum rate is one write per two cycles.
REQ-018 SHALL, on an accept with cfg_ch<NCH, load num/den/phase into that channel, set acc=phase (or 0 if phase>=den), and force cen[ch]=0 on that same edge.
REQ-019 SHALL ignore the data of an accept with cfg_ch>=NCH, while still applying the cfg_ready low cycle; locked is unaffected.
REQ-020 SHALL, on every other edge for each enabled channel, compute s=acc+num at ACC_W+1 bits; if s>=den then acc<=s-den and cen<=1, else acc<=s and cen<=0.
REQ-021 SHALL treat a channel with num=0 or den=0 as disabled: cen=0 and acc held.
REQ-022 SHALL treat num>den as num=den, giving cen=1 on every cycle.
REQ-023 SHALL, when resync=1, set acc<=stored phase (with the same clamp as REQ-018) for every channel and force cen=0 on that edge.
REQ-024 SHALL let resync take priority over accumulation; a same-edge accept still loads its channel from the cfg_* inputs.
REQ-025 SHALL, for the lock counter, clear the counter and set locked=0 on any accept to a valid channel or on resync.
REQ-026 SHALL otherwise increment the lock counter saturating at LOCK_CYCLES, and set locked=1 on the edge the count reaches LOCK_CYCLES.
REQ-027 SHALL give a latency of 1 cycle from accept to the first accumulate edge; the first cen high is registered on edge k, the first k>=1 with phase+k*num>=den.

Reset
REQ-028 SHALL, while rst=1, set every channel num=0, den=0, phase=0, acc=0, so all channels are disabled.
REQ-029 SHALL, while rst=1, set cen=0, locked=0, lock counter=0 and cfg_ready=1.
REQ-030 SHALL have rst override any accept or resync on the same edge.
REQ-031 SHALL start lock counting on the first edge after rst deasserts; locked rises after LOCK_CYCLES edges.
REQ-032 SHALL let rst asserted mid-pattern abort all outputs on that edge, with no pending pulse afterwards.

Verification
REQ-033 SHALL be verified by: write ch0 num=1, den=4, phase=0 -> cen[0] high on edges 4, 8, 12… after the accept, with a period of exactly 4.
REQ-034 SHALL be verified by: ch1 num=3, den=8, phase=0 -> cen[1] high on edges 3, 6, 8, then the pattern repeats every 8 cycles (3 pulses per 8).
REQ-035 SHALL be verified by: ch0 num=1, den=4, phase=2 -> first cen[0] on edge 2, then every 4 cycles; asserting resync mid-run restarts at edge 2 relative to resync.
REQ-036 SHALL be verified by: reset release with LOCK_CYCLES=64 -> locked=1 after edge 64; a write at edge 100 drops locked on the next edge and it returns 64 edges later.
REQ-037 SHALL be verified by: cfg_valid held high for 6 cycles -> 3 accepts with cfg_ready pattern 1,0,1,0,1,0; cfg_ch=7 with NCH=2 -> no state change and locked stays high.
REQ-038 SHALL be verified by: num=0, den=5, and separately num=9, den=5 -> cen constant 0, and cen constant 1 respectively.

Source files
------------

// File: rtl/clken_gen.sv
// Fractional clock-enable generator: per channel, pulses num times every den cycles
// using a phase-preloaded accumulator, plus a settle counter that reports lock.
module clken_gen #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  input  logic [ACC_W-1:0] cfg_phase,
  input  logic             resync,
  output logic [NCH-1:0]   cen,
  output logic             locked
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES + 1);

  logic [ACC_W-1:0] num_q   [NCH];
  logic [ACC_W-1:0] num_d   [NCH];
  logic [ACC_W-1:0] den_q   [NCH];
  logic [ACC_W-1:0] den_d   [NCH];
  logic [ACC_W-1:0] phase_q [NCH];
  logic [ACC_W-1:0] phase_d [NCH];
  logic [ACC_W-1:0] acc_q   [NCH];
  logic [ACC_W-1:0] acc_d   [NCH];
  logic [ACC_W-1:0] step    [NCH];
  logic [ACC_W:0]   sum     [NCH];
  logic [ACC_W:0]   diff    [NCH];

  logic [NCH-1:0]  cen_q, cen_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            locked_q, locked_d;
  logic            ready_q, ready_d;
  logic            accept, cfg_hit;

  // A phase at or beyond den would never wrap correctly, so it starts from zero instead.
  function automatic logic [ACC_W-1:0] clamp_phase(input logic [ACC_W-1:0] p,
                                                   input logic [ACC_W-1:0] d);
    return (p >= d) ? '0 : p;
  endfunction

  always_comb begin
    accept  = cfg_valid & ready_q;
    cfg_hit = accept && (32'(cfg_ch) < NCH);
    ready_d = ~accept;

    for (int i = 0; i < NCH; i++) begin
      num_d[i]   = num_q[i];
      den_d[i]   = den_q[i];
      phase_d[i] = phase_q[i];
      acc_d[i]   = acc_q[i];
      cen_d[i]   = 1'b0;
      // num above den saturates to one pulse per cycle
      step[i]    = (num_q[i] > den_q[i]) ? den_q[i] : num_q[i];
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, step[i]};
      diff[i]    = sum[i] - {1'b0, den_q[i]};

      if (cfg_hit && (cfg_ch == 3'(i))) begin
        num_d[i]   = cfg_num;
        den_d[i]   = cfg_den;
        phase_d[i] = cfg_phase;
        acc_d[i]   = clamp_phase(cfg_phase, cfg_den);
      end else if (resync) begin
        acc_d[i] = clamp_phase(phase_q[i], den_q[i]);
      end else if ((num_q[i] != '0) && (den_q[i] != '0)) begin
        if (sum[i] >= {1'b0, den_q[i]}) begin
          acc_d[i] = diff[i][ACC_W-1:0];
          cen_d[i] = 1'b1;
        end else begin
          acc_d[i] = sum[i][ACC_W-1:0];
        end
      end
    end

    if (cfg_hit || resync) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      cnt_d    = (cnt_q == CntW'(LOCK_CYCLES)) ? cnt_q : cnt_q + CntW'(1);
      locked_d = (cnt_d == CntW'(LOCK_CYCLES));
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        num_q[i]   <= '0;
        den_q[i]   <= '0;
        phase_q[i] <= '0;
        acc_q[i]   <= '0;
      end
      cen_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        num_q[i]   <= num_d[i];
        den_q[i]   <= den_d[i];
        phase_q[i] <= phase_d[i];
        acc_q[i]   <= acc_d[i];
      end
      cen_q    <= cen_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
    end
  end

  assign cen       = cen_q;
  assign locked    = locked_q;
  assign cfg_ready = ready_q;

endmodule

// File: tb/tb_clken_gen.sv
// Randomized scoreboard bench for clken_gen; expected pulses come from a closed-form
// floor((phase + k*num) / den) model of each channel.
module tb_clken_gen;

  localparam int NCH   = 2;
  localparam int ACC_W = 16;
  localparam int LOCK  = 64;

  logic             refclk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic [ACC_W-1:0] cfg_phase;
  logic             resync;
  logic [NCH-1:0]   cen;
  logic             locked;

  clken_gen #(
    .NCH        (NCH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_phase(cfg_phase),
    .resync   (resync),
    .cen      (cen),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [NCH-1:0] cen;
    logic           locked;
    logic           ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: configuration plus edges elapsed since the last load/resync.
  longint m_num[NCH];
  longint m_den[NCH];
  longint m_p0[NCH];
  longint m_k[NCH];
  longint m_since;
  bit     m_ready;

  task automatic step(input bit r, input bit v, input int ch, input int n, input int d,
                      input int p, input bit rs);
    exp_t   e;
    bit     acc_ok;
    bit     hit;
    longint nn;
    rst       = r;
    cfg_valid = v;
    cfg_ch    = 3'(ch);
    cfg_num   = ACC_W'(n);
    cfg_den   = ACC_W'(d);
    cfg_phase = ACC_W'(p);
    resync    = rs;
    e.cen     = '0;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_num[c] = 0;
        m_den[c] = 0;
        m_p0[c]  = 0;
        m_k[c]   = 0;
      end
      m_since  = 0;
      m_ready  = 1'b1;
      e.locked = 1'b0;
      e.ready  = 1'b1;
    end else begin
      acc_ok = v && m_ready;
      hit    = acc_ok && (ch < NCH);
      for (int c = 0; c < NCH; c++) begin
        if (hit && ch == c) begin
          m_num[c] = n;
          m_den[c] = d;
          m_p0[c]  = (p >= d) ? 0 : p;
          m_k[c]   = 0;
        end else if (rs) begin
          m_k[c] = 0;
        end else if (m_num[c] != 0 && m_den[c] != 0) begin
          nn     = (m_num[c] > m_den[c]) ? m_den[c] : m_num[c];
          m_k[c] = m_k[c] + 1;
          e.cen[c] = ((m_p0[c] + m_k[c] * nn) / m_den[c]) !=
                     ((m_p0[c] + (m_k[c] - 1) * nn) / m_den[c]);
        end
      end
      if (hit || rs) m_since = 0;
      else m_since = m_since + 1;
      e.locked = (m_since >= LOCK);
      e.ready  = !acc_ok;
      m_ready  = !acc_ok;
    end
    exp_q.push_back(e);
    @(posedge refclk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic write(input int ch, input int n, input int d, input int p);
    step(1'b0, 1'b1, ch, n, d, p, 1'b0);
  endtask

  // Monitor: outputs are stable at the falling edge, one expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cen !== e.cen) begin
          errors++;
          $display("FAIL cen t=%0t got %b exp %b", $time, cen, e.cen);
        end
        checks++;
        if (locked !== e.locked) begin
          errors++;
          $display("FAIL locked t=%0t got %b exp %b", $time, locked, e.locked);
        end
        checks++;
        if (cfg_ready !== e.ready) begin
          errors++;
          $display("FAIL cfg_ready t=%0t got %b exp %b", $time, cfg_ready, e.ready);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    idle(70);                      // locked rises after edge 64
    write(0, 1, 4, 0);             // period-4 enables
    idle(20);
    write(1, 3, 8, 0);             // 3 pulses per 8
    idle(30);
    write(0, 1, 4, 2);             // phase offset 2
    idle(9);
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    idle(80);                      // relock after resync
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 7, 5, 5, 5, 1'b0);
    idle(4);
    write(0, 0, 5, 0);             // disabled
    write(1, 9, 5, 0);             // saturated
    idle(12);
    step(1'b0, 1'b1, 1, 1, 3, 0, 1'b1);  // same-edge accept and resync
    idle(5);
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);  // mid-pattern reset
    idle(5);
    write(0, 5, 7, 9);             // phase clamp
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7))
                                       : int'($urandom_range(0, NCH - 1)),
           int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
           int'($urandom_range(0, 24)), ($urandom_range(0, 99) == 0));
    end
    idle(2);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge refclk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
